hazard_tracker: RTL

//   Producer side of the register-forwarding interface in the 5-stage pipelined CPU. Tracks destination-register

---
 rtl/hazard_tracker.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Destination-register tracking through ID/EX, EX/MEM and MEM/WB for forwarding,
// with load-use interlock, taken-branch squash and data-memory freeze control.
module hazard_tracker #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_if_id,
    output logic [REG_W-1:0] idex_rd,
    output logic             idex_regwrite,
    output logic [REG_W-1:0] exmem_rd,
    output logic             exmem_regwrite,
    output logic [REG_W-1:0] memwb_rd,
    output logic             memwb_regwrite,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } entry_t;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        INTERLOCK = 2'b01,
        FREEZE    = 2'b10
    } state_t;

    entry_t idex_q, exmem_q, memwb_q;
    entry_t idex_d, exmem_d, memwb_d;
    entry_t bubble, incoming;
    state_t state_q, state_d;
    logic   load_use;
    logic   src_hit;

    always_comb begin
        bubble          = '0;
        bubble.rd       = ZR;
        // regwrite is qualified on entry so the registered bit feeds forwarding directly
        incoming          = '0;
        incoming.valid    = id_valid;
        incoming.rd       = id_rd;
        incoming.regwrite = id_valid & id_regwrite & (id_rd != ZR);
        incoming.memread  = id_valid & id_memread;
    end

    always_comb begin
        src_hit  = (id_rn_used & (id_rn == idex_q.rd))
                 | (id_rm_used & (id_rm == idex_q.rd));
        load_use = id_valid & idex_q.valid & idex_q.memread
                 & idex_q.regwrite & (idex_q.rd != ZR) & src_hit;
    end

    always_comb begin
        idex_d      = incoming;
        exmem_d     = idex_q;
        memwb_d     = exmem_q;
        state_d     = RUN;
        stall_if_id = 1'b0;
        if (reset) begin
            stall_if_id = 1'b0;
        end else if (mem_busy) begin
            idex_d      = idex_q;
            exmem_d     = exmem_q;
            memwb_d     = memwb_q;
            stall_if_id = 1'b1;
            state_d     = FREEZE;
        end else if (branch_taken) begin
            idex_d = bubble;
        end else if (load_use) begin
            idex_d      = bubble;
            stall_if_id = 1'b1;
            state_d     = INTERLOCK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q       <= bubble;
            exmem_q      <= bubble;
            memwb_q      <= bubble;
            state_q      <= RUN;
            stall_cycles <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            state_q <= state_d;
            if (stall_if_id && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign idex_rd        = idex_q.rd;
    assign idex_regwrite  = idex_q.regwrite;
    assign exmem_rd       = exmem_q.rd;
    assign exmem_regwrite = exmem_q.regwrite;
    assign memwb_rd       = memwb_q.rd;
    assign memwb_regwrite = memwb_q.regwrite;
    assign state          = state_q;

endmodule
